// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the read side of the UART FIFO and
// emits start / data (LSB first) / optional parity / stop frames on tx.
`timescale 1ns/1ps
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 139,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == CNT_LAST);

    // every bit-timed state runs the same wrapping baud counter
    if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (tx_en && !fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = fifo_dout;
        par_d   = parity_of(fifo_dout);
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // idx counts stop bits; fifo_empty is re-sampled only on the final edge
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = (tx_en && !fifo_empty) ? S_FETCH : S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_en = (state_q == S_FETCH);
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: one 8N1 instance plus odd/even parity 2-stop
// instances, each fed by a queue-like FIFO model and checked against frame bits.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tx_en;
  logic [2:0] fifo_empty;
  logic [7:0] fifo_dout [3];
  logic [2:0] rd_en, tx, busy, done;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                       .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_dout(fifo_dout[0]), .fifo_rd_en(rd_en[0]), .tx(tx[0]),
    .busy(busy[0]), .tx_done(done[0]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                       .PARITY_ODD(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_dout(fifo_dout[1]), .fifo_rd_en(rd_en[1]), .tx(tx[1]),
    .busy(busy[1]), .tx_done(done[1]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                       .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_en(tx_en[2]), .fifo_empty(fifo_empty[2]),
    .fifo_dout(fifo_dout[2]), .fifo_rd_en(rd_en[2]), .tx(tx[2]),
    .busy(busy[2]), .tx_done(done[2]));

  // FIFO models and event monitors
  logic [7:0] mem [3][64];
  int wr_ptr [3] = '{0, 0, 0};
  int rd_ptr [3] = '{0, 0, 0};
  int rd_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int viol_cnt [3] = '{0, 0, 0};
  int dbl_cnt [3] = '{0, 0, 0};
  logic [2:0] rd_prev = 3'b000;

  assign fifo_empty[0] = (wr_ptr[0] == rd_ptr[0]);
  assign fifo_empty[1] = (wr_ptr[1] == rd_ptr[1]);
  assign fifo_empty[2] = (wr_ptr[2] == rd_ptr[2]);

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i] === 1'b1) begin
        rd_cnt[i] <= rd_cnt[i] + 1;
        if (fifo_empty[i]) viol_cnt[i] <= viol_cnt[i] + 1;
        else begin
          fifo_dout[i] <= mem[i][rd_ptr[i] % 64];
          rd_ptr[i]    <= rd_ptr[i] + 1;
        end
        if (rd_prev[i] === 1'b1) dbl_cnt[i] <= dbl_cnt[i] + 1;
      end
      if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
      rd_prev[i] <= rd_en[i];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic [7:0] b);
    mem[d][wr_ptr[d] % 64] = b;
    wr_ptr[d] = wr_ptr[d] + 1;
  endtask

  // Reference frame: start, 8 data LSB first, parity (d>0), stop bits
  function automatic int frame_len(input int d);
    return (d == 0) ? 10 : 12;
  endfunction

  function automatic logic frame_bit(input int d, input logic [7:0] b, input int k);
    int ones;
    ones = $countones(b);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (d > 0 && k == 9) begin
      if (d == 1) return (ones % 2 == 0) ? 1'b1 : 1'b0;
      else        return (ones % 2 == 1) ? 1'b1 : 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic frame_check(input int d, input logic [7:0] b, input int drop_t,
                             output int waited);
    int n;
    int len;
    n   = 0;
    len = frame_len(d);
    while (tx[d] === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    waited = n;
    chk($sformatf("d%0d_fall_wait", d), 32'(n < 2000), 32'd1);
    if (n >= 2000) return;
    for (int t = 0; t <= len * CPB; t++) begin
      if (t == drop_t) tx_en[d] = 1'b0;
      if (t % CPB == CPB / 2 && t / CPB < len)
        chk($sformatf("d%0d_%02h_bit%0d", d, b, t / CPB), 32'(tx[d]),
            32'(frame_bit(d, b, t / CPB)));
      if (t == CPB / 2) chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'd1);
      if (t == len * CPB - 1) chk($sformatf("d%0d_done_early", d), 32'(done[d]), 32'd0);
      if (t == len * CPB) chk($sformatf("d%0d_done_pulse", d), 32'(done[d]), 32'd1);
      if (t < len * CPB) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, rdc, dc, low;
    logic [7:0] rb;

    // Reset held with data pending and tx_en high
    rst   = 1'b1;
    tx_en = 3'b111;
    push(0, 8'h55);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("reset_outs", 32'({tx[0], busy[0], rd_en[0], done[0]}), 32'b1000);
    end
    chk("reset_no_pop", 32'(rd_cnt[0]), 32'd0);

    // Single byte 0x55: fetch, load, then tx falls
    rst = 1'b0;
    tick();
    chk("fetch_rd_en", 32'({rd_en[0], busy[0], tx[0]}), 32'b111);
    tick();
    chk("load_cycle", 32'({rd_en[0], tx[0]}), 32'b01);
    tick();
    chk("tx_fall_e2", 32'(tx[0]), 32'd0);
    frame_check(0, 8'h55, -1, w);
    chk("single_wait", 32'(w), 32'd0);
    tick();
    chk("busy_drop", 32'(busy[0]), 32'd0);
    chk("single_rd_cnt", 32'(rd_cnt[0]), 32'd1);

    // Back-to-back directed bytes
    rdc = rd_cnt[0];
    dc  = done_cnt[0];
    for (int i = 0; i < 4; i++) push(0, 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      frame_check(0, 8'h10 + 8'(i), -1, w);
      chk($sformatf("b2b_gap%0d", i), 32'(w), (i == 0) ? 32'd3 : 32'd2);
    end
    repeat (3) tick();
    chk("b2b_rd_cnt", 32'(rd_cnt[0] - rdc), 32'd4);
    chk("b2b_done_cnt", 32'(done_cnt[0] - dc), 32'd4);

    // Randomized back-to-back bytes
    begin
      logic [7:0] rq [$];
      for (int i = 0; i < 6; i++) begin
        rb = 8'($urandom);
        rq.push_back(rb);
        push(0, rb);
      end
      for (int i = 0; i < 6; i++) begin
        frame_check(0, rq[i], -1, w);
        chk($sformatf("rnd_gap%0d", i), 32'(w), (i == 0) ? 32'd3 : 32'd2);
      end
    end
    repeat (3) tick();

    // Parity instances, 2 stop bits
    for (int d = 1; d < 3; d++) begin
      push(d, 8'hAB);
      frame_check(d, 8'hAB, -1, w);
      rb = 8'($urandom);
      push(d, rb);
      repeat (2) tick();
      frame_check(d, rb, -1, w);
      repeat (2) tick();
      chk($sformatf("par%0d_rd_cnt", d), 32'(rd_cnt[d]), 32'd2);
    end

    // Reset during data bit 3 of 0xF0
    push(0, 8'hF0);
    w = 0;
    while (tx[0] === 1'b1 && w < 100) begin tick(); w++; end
    repeat (4 * CPB + CPB / 2) tick();
    chk("abort_bit3", 32'(tx[0]), 32'(frame_bit(0, 8'hF0, 4)));
    dc  = done_cnt[0];
    rst = 1'b1;
    tick();
    chk("abort_outs", 32'({tx[0], busy[0], rd_en[0], done[0]}), 32'b1000);
    push(0, 8'h3C);
    rdc = rd_cnt[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_hold_outs", 32'({tx[0], busy[0], rd_en[0], done[0]}), 32'b1000);
    end
    chk("rst_hold_no_pop", 32'(rd_cnt[0] - rdc), 32'd0);
    rst = 1'b0;
    frame_check(0, 8'h3C, -1, w);
    chk("post_rst_lat", 32'(w), 32'd3);
    chk("abort_no_done", 32'(done_cnt[0] - dc), 32'd0);
    repeat (3) tick();

    // Flow control: tx_en low blocks fetches
    tx_en[0] = 1'b0;
    push(0, 8'h5A);
    push(0, 8'hC3);
    rdc = rd_cnt[0];
    low = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (tx[0] !== 1'b1 || rd_en[0] !== 1'b0) low++;
    end
    chk("flow_no_pop", 32'(rd_cnt[0] - rdc), 32'd0);
    chk("flow_line_idle", 32'(low), 32'd0);
    tx_en[0] = 1'b1;
    frame_check(0, 8'h5A, 5 * CPB, w);
    low = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx[0] !== 1'b1 || rd_en[0] !== 1'b0) low++;
    end
    chk("flow_stop_pop", 32'(rd_cnt[0] - rdc), 32'd1);
    chk("flow_stop_idle", 32'(low), 32'd0);
    chk("flow_busy_low", 32'(busy[0]), 32'd0);
    tx_en[0] = 1'b1;
    frame_check(0, 8'hC3, -1, w);
    chk("flow_resume_lat", 32'(w), 32'd3);
    repeat (3) tick();

    chk("rd_while_empty", 32'(viol_cnt[0] + viol_cnt[1] + viol_cnt[2]), 32'd0);
    chk("rd_pulse_width", 32'(dbl_cnt[0] + dbl_cnt[1] + dbl_cnt[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
